dmmu_pt_loader: RTL and testbench

- Hardware page-table loader that fills the data MMU's 16 page entries from memory, so software does not issue 16 individual SR writes.
- It is the writer for the MMU's SR-write page-table port.
- Programmed through three SR registers. Fetches entries over a word-addressed req/ack memory port, then drives one SR write per entry into the MMU page-table range (0x200..0x20F).
- Sits beside dmmu. Its o_sr_* bus is OR-merged with the CPU SR write bus at integration.

---
 rtl/dmmu_pt_loader.sv | 175 +++++++++++++++++
 tb/tb_dmmu_pt_loader.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmmu_pt_loader.sv
// dmmu_pt_loader: hardware page-table loader for the data MMU.
// It fetches up to ENTRIES words from a word-addressed req/ack memory port.
// Each word is then written into the MMU page-table SR range.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_sr_addr/data/we         CPU SR bus (loader config registers)
//   o_mem_req/addr            memory read request and word address
//   i_mem_ack/err/data        memory response (err terminates like ack)
//   o_sr_addr/data/we         SR write bus to the MMU (zero outside writes)
//   o_busy, o_done, o_err     status: load active, completion pulse, sticky error
module dmmu_pt_loader #(
  parameter logic [15:0] CFG_SR_BASE = 16'h218,
  parameter logic [15:0] PT_SR_BASE  = 16'h200,
  parameter int unsigned ENTRIES     = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_sr_addr,
  input  logic [15:0] i_sr_data,
  input  logic        i_sr_we,
  output logic        o_mem_req,
  output logic [23:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic        i_mem_err,
  input  logic [15:0] i_mem_data,
  output logic [15:0] o_sr_addr,
  output logic [15:0] o_sr_data,
  output logic        o_sr_we,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int unsigned IW = $clog2(ENTRIES);
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [IW-1:0]   first_q, first_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   pt_idx;

  logic            req_d;
  logic [AW-1:0]   mem_addr_d;
  logic            sr_we_d;
  logic [DW-1:0]   sr_addr_d;
  logic [DW-1:0]   sr_data_d;
  logic            busy_d;
  logic            done_d;
  logic            err_d;

  logic            wr_lo, wr_hi, wr_ctl;

  // Config register decode
  assign wr_lo  = i_sr_we && (i_sr_addr == CFG_SR_BASE);
  assign wr_hi  = i_sr_we && (i_sr_addr == 16'(CFG_SR_BASE + 16'd1));
  assign wr_ctl = i_sr_we && (i_sr_addr == 16'(CFG_SR_BASE + 16'd2));

  // Next-state and next-output logic; every output is registered from its _d value
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    first_d    = first_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pt_idx     = first_q + idx_q;
    req_d      = 1'b0;
    mem_addr_d = '0;
    sr_we_d    = 1'b0;
    sr_addr_d  = '0;
    sr_data_d  = '0;
    done_d     = 1'b0;
    err_d      = o_err;

    // Base is frozen while a load is running
    if (wr_lo && (state_q == S_IDLE)) begin
      base_d[15:0] = i_sr_data;
    end
    if (wr_hi && (state_q == S_IDLE)) begin
      base_d[23:16] = i_sr_data[7:0];
    end
    if (wr_ctl && i_sr_data[14]) begin
      err_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_ctl && i_sr_data[15]) begin
          first_d = i_sr_data[IW-1:0];
          cnt_d   = i_sr_data[4 +: IW];
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Error wins over ack; the entry is dropped without an SR write
        if (o_mem_req && i_mem_err) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (o_mem_req && i_mem_ack) begin
          sr_we_d   = 1'b1;
          sr_addr_d = PT_SR_BASE + DW'(pt_idx);
          sr_data_d = i_mem_data;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (idx_q == cnt_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Request and address are derived from the next state so they are stable for all of FETCH
    if (state_d == S_FETCH) begin
      req_d      = 1'b1;
      mem_addr_d = base_d + AW'(idx_d);
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      first_q    <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      o_mem_req  <= 1'b0;
      o_mem_addr <= '0;
      o_sr_we    <= 1'b0;
      o_sr_addr  <= '0;
      o_sr_data  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      first_q    <= first_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      o_mem_req  <= req_d;
      o_mem_addr <= mem_addr_d;
      o_sr_we    <= sr_we_d;
      o_sr_addr  <= sr_addr_d;
      o_sr_data  <= sr_data_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
      o_err      <= err_d;
    end
  end

endmodule

// File: tb/tb_dmmu_pt_loader.sv
// Testbench for dmmu_pt_loader: memory responder, SR-write scoreboard and scenario tasks.
module tb_dmmu_pt_loader;

  localparam int unsigned PERIOD = 10;
  localparam logic [15:0] CFG    = 16'h218;

  logic        i_clk;
  logic        i_rst_n;
  logic [15:0] i_sr_addr;
  logic [15:0] i_sr_data;
  logic        i_sr_we;
  logic        o_mem_req;
  logic [23:0] o_mem_addr;
  logic        i_mem_ack;
  logic        i_mem_err;
  logic [15:0] i_mem_data;
  logic [15:0] o_sr_addr;
  logic [15:0] o_sr_data;
  logic        o_sr_we;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  dmmu_pt_loader dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_sr_addr  (i_sr_addr),
    .i_sr_data  (i_sr_data),
    .i_sr_we    (i_sr_we),
    .o_mem_req  (o_mem_req),
    .o_mem_addr (o_mem_addr),
    .i_mem_ack  (i_mem_ack),
    .i_mem_err  (i_mem_err),
    .i_mem_data (i_mem_data),
    .o_sr_addr  (o_sr_addr),
    .o_sr_data  (o_sr_data),
    .o_sr_we    (o_sr_we),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #(PERIOD / 2) i_clk = ~i_clk;
  end

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } sr_t;

  sr_t         exp_sr[$];
  logic [23:0] exp_mem[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          done_cnt    = 0;
  int          lat         = 0;
  int          err_at      = -1;
  int          req_num     = 0;
  bit          stray       = 1'b0;
  logic [23:0] origin      = 24'h0;
  time         t_wr        = 0;

  // Memory content: word k of the current table is 0x1000+k
  function automatic logic [15:0] mem_word(input logic [23:0] a);
    logic [23:0] d;
    d = a - origin;
    return 16'h1000 + d[15:0];
  endfunction

  // Memory responder: ack (or err) after lat wait cycles, checks address order and stability
  initial begin
    int          wcnt;
    logic [23:0] hold;
    logic [23:0] e;
    wcnt = 0;
    hold = '0;
    forever begin
      @(negedge i_clk);
      i_mem_ack  = 1'b0;
      i_mem_err  = 1'b0;
      i_mem_data = 16'h0;
      if (!i_rst_n) begin
        wcnt = 0;
      end else if (o_mem_req) begin
        if (wcnt == 0) begin
          hold = o_mem_addr;
        end else begin
          vectors++;
          if (o_mem_addr !== hold) begin
            miscompares++;
            $display("FAIL mem_addr_hold: got %h want %h", o_mem_addr, hold);
          end
        end
        if (wcnt >= lat) begin
          vectors++;
          if (exp_mem.size() == 0) begin
            miscompares++;
            $display("FAIL mem_req_unexpected: got addr %h want no request", o_mem_addr);
          end else begin
            e = exp_mem.pop_front();
            if (o_mem_addr !== e) begin
              miscompares++;
              $display("FAIL mem_addr: got %h want %h", o_mem_addr, e);
            end
          end
          if (req_num == err_at) begin
            i_mem_err = 1'b1;
          end else begin
            i_mem_ack  = 1'b1;
            i_mem_data = mem_word(o_mem_addr);
          end
          req_num++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else if (stray) begin
        i_mem_ack  = 1'b1;
        i_mem_data = 16'($urandom);
      end
    end
  end

  // SR-write scoreboard and done-pulse counter
  initial begin
    sr_t e;
    sr_t got;
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        got = {o_sr_addr, o_sr_data};
        if (o_sr_we) begin
          vectors++;
          if (exp_sr.size() == 0) begin
            miscompares++;
            $display("FAIL sr_write_unexpected: got %h/%h want none", o_sr_addr, o_sr_data);
          end else begin
            e = exp_sr.pop_front();
            if (got !== e) begin
              miscompares++;
              $display("FAIL sr_write: got %h/%h want %h/%h", got.addr, got.data, e.addr, e.data);
            end
          end
        end else if (got !== 32'h0) begin
          vectors++;
          miscompares++;
          $display("FAIL sr_bus_idle: got %h/%h want 0/0", o_sr_addr, o_sr_data);
        end
        if (o_done) done_cnt++;
      end
    end
  end

  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic sr_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge i_clk);
    i_sr_addr = a;
    i_sr_data = d;
    i_sr_we   = 1'b1;
    @(posedge i_clk);
    t_wr = $time;
    @(negedge i_clk);
    i_sr_we   = 1'b0;
    i_sr_addr = 16'h0;
    i_sr_data = 16'h0;
  endtask

  // Queue the expected memory reads and SR writes, then issue the start write
  task automatic start_load(input logic [23:0] base, input logic [15:0] ctrl, input bit wr_base,
                            input int lat_i, input int err_i);
    int          n;
    logic [3:0]  first;
    logic [3:0]  pidx;
    if (wr_base) begin
      sr_wr(CFG, base[15:0]);
      sr_wr(16'(CFG + 16'd1), {8'h00, base[23:16]});
    end
    lat      = lat_i;
    err_at   = err_i;
    req_num  = 0;
    origin   = base;
    done_cnt = 0;
    first    = ctrl[3:0];
    n        = int'(ctrl[7:4]) + 1;
    for (int k = 0; k < n; k++) begin
      pidx = 4'(int'(first) + k);
      if (err_i < 0 || k < err_i) exp_sr.push_back({16'h200 + 16'(pidx), 16'h1000 + 16'(k)});
      if (err_i < 0 || k <= err_i) exp_mem.push_back(base + 24'(k));
    end
    sr_wr(16'(CFG + 16'd2), ctrl);
  endtask

  task automatic wait_idle(input int budget, input time t0, output int cycles);
    bit ok;
    ok     = 1'b0;
    cycles = -1;
    for (int c = 0; c < budget; c++) begin
      @(posedge i_clk);
      #1;
      if (!o_busy) begin
        ok     = 1'b1;
        cycles = int'(($time - 1 - t0) / PERIOD);
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_idle: o_busy still %b after %0d cycles, want 0", o_busy, budget);
    end
  endtask

  task automatic test_reset();
    logic [60:0] outs;
    int cyc;
    time t0;
    #1 i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    outs = {o_mem_req, o_mem_addr, o_sr_we, o_sr_addr, o_sr_data, o_busy, o_done, o_err};
    vectors++;
    if (outs !== 61'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    outs = {o_mem_req, o_mem_addr, o_sr_we, o_sr_addr, o_sr_data, o_busy, o_done, o_err};
    vectors++;
    if (outs !== 61'h0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %h want 0", outs);
    end
    // Base must come out of reset as 0: a single-entry load reads address 0
    start_load(24'h0, 16'h8000, 1'b0, 0, -1);
    t0 = t_wr;
    wait_idle(20, t0, cyc);
    vectors++;
    if (done_cnt !== 1 || exp_sr.size() != 0 || exp_mem.size() != 0) begin
      miscompares++;
      $display("FAIL reset_base_load: done=%0d sr_left=%0d mem_left=%0d want 1/0/0",
               done_cnt, exp_sr.size(), exp_mem.size());
    end
  endtask

  task automatic test_full_load();
    int cyc;
    time t0;
    start_load(24'h012340, 16'h80F0, 1'b1, 0, -1);
    t0 = t_wr;
    wait_idle(100, t0, cyc);
    vectors++;
    if (cyc !== 33) begin
      miscompares++;
      $display("FAIL full_load_cycles: got %0d want 33", cyc);
    end
    vectors++;
    if (done_cnt !== 1 || o_err !== 1'b0 || exp_sr.size() != 0 || exp_mem.size() != 0) begin
      miscompares++;
      $display("FAIL full_load_end: done=%0d err=%b sr_left=%0d mem_left=%0d want 1/0/0/0",
               done_cnt, o_err, exp_sr.size(), exp_mem.size());
    end
  endtask

  task automatic test_wrap();
    int cyc;
    time t0;
    stray = 1'b1;
    start_load(24'h000100, 16'h803E, 1'b1, 0, -1);
    t0 = t_wr;
    wait_idle(40, t0, cyc);
    stray = 1'b0;
    vectors++;
    if (cyc !== 9 || done_cnt !== 1 || exp_sr.size() != 0 || exp_mem.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_end: cycles=%0d done=%0d sr_left=%0d mem_left=%0d want 9/1/0/0",
               cyc, done_cnt, exp_sr.size(), exp_mem.size());
    end
  endtask

  task automatic test_wait_states();
    int cyc;
    time t0;
    start_load(24'hFFFFFE, 16'h8020, 1'b1, 3, -1);
    t0 = t_wr;
    wait_idle(60, t0, cyc);
    vectors++;
    if (cyc !== 16) begin
      miscompares++;
      $display("FAIL wait_states_cycles: got %0d want 16", cyc);
    end
    vectors++;
    if (done_cnt !== 1 || exp_sr.size() != 0 || exp_mem.size() != 0) begin
      miscompares++;
      $display("FAIL wait_states_end: done=%0d sr_left=%0d mem_left=%0d want 1/0/0",
               done_cnt, exp_sr.size(), exp_mem.size());
    end
  endtask

  task automatic test_error();
    int cyc;
    time t0;
    start_load(24'h000400, 16'h8030, 1'b1, 0, 2);
    t0 = t_wr;
    wait_idle(40, t0, cyc);
    vectors++;
    if (o_err !== 1'b1 || o_busy !== 1'b0 || done_cnt !== 0) begin
      miscompares++;
      $display("FAIL error_abort: err=%b busy=%b done=%0d want 1/0/0", o_err, o_busy, done_cnt);
    end
    vectors++;
    if (exp_sr.size() != 0 || exp_mem.size() != 0) begin
      miscompares++;
      $display("FAIL error_drain: sr_left=%0d mem_left=%0d want 0/0", exp_sr.size(), exp_mem.size());
    end
    sr_wr(16'(CFG + 16'd2), 16'h4000);
    vectors++;
    if (o_err !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_err: got %b want 0", o_err);
    end
  endtask

  task automatic test_start_clears_err();
    int cyc;
    time t0;
    start_load(24'h000500, 16'h8000, 1'b1, 0, 0);
    t0 = t_wr;
    wait_idle(20, t0, cyc);
    vectors++;
    if (o_err !== 1'b1 || done_cnt !== 0) begin
      miscompares++;
      $display("FAIL err_first_entry: err=%b done=%0d want 1/0", o_err, done_cnt);
    end
    start_load(24'h000500, 16'h8010, 1'b0, 0, -1);
    t0 = t_wr;
    vectors++;
    if (o_err !== 1'b0 || o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_clears_err: err=%b busy=%b want 0/1", o_err, o_busy);
    end
    wait_idle(20, t0, cyc);
    vectors++;
    if (done_cnt !== 1 || exp_sr.size() != 0 || exp_mem.size() != 0) begin
      miscompares++;
      $display("FAIL restart_after_err: done=%0d sr_left=%0d mem_left=%0d want 1/0/0",
               done_cnt, exp_sr.size(), exp_mem.size());
    end
  endtask

  task automatic test_busy_writes();
    int cyc;
    time t0;
    start_load(24'h000800, 16'h8050, 1'b1, 1, -1);
    t0 = t_wr;
    sr_wr(CFG, 16'hDEAD);
    sr_wr(16'(CFG + 16'd1), 16'h0055);
    sr_wr(16'(CFG + 16'd2), 16'h80F3);
    sr_wr(16'(CFG + 16'd2), 16'h4000);
    wait_idle(60, t0, cyc);
    vectors++;
    if (cyc !== 19 || done_cnt !== 1 || o_err !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_writes_run: cycles=%0d done=%0d err=%b want 19/1/0", cyc, done_cnt, o_err);
    end
    vectors++;
    if (exp_sr.size() != 0 || exp_mem.size() != 0) begin
      miscompares++;
      $display("FAIL busy_writes_drain: sr_left=%0d mem_left=%0d want 0/0", exp_sr.size(), exp_mem.size());
    end
    // Base written while busy must not have stuck
    start_load(24'h000800, 16'h8010, 1'b0, 0, -1);
    t0 = t_wr;
    wait_idle(20, t0, cyc);
    vectors++;
    if (done_cnt !== 1 || exp_sr.size() != 0 || exp_mem.size() != 0) begin
      miscompares++;
      $display("FAIL base_kept: done=%0d sr_left=%0d mem_left=%0d want 1/0/0",
               done_cnt, exp_sr.size(), exp_mem.size());
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [60:0] outs;
    int  cyc;
    time t0;
    bit  seen;
    start_load(24'h000900, 16'h8090, 1'b1, 5, -1);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (o_mem_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL reset_mid_req_seen: o_mem_req %b want 1", o_mem_req);
    end
    #2 i_rst_n = 1'b0;
    #1;
    outs = {o_mem_req, o_mem_addr, o_sr_we, o_sr_addr, o_sr_data, o_busy, o_done, o_err};
    vectors++;
    if (outs !== 61'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h want 0", outs);
    end
    exp_sr.delete();
    exp_mem.delete();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      vectors++;
      if ({o_sr_we, o_busy, o_mem_req} !== 3'b000) begin
        miscompares++;
        $display("FAIL after_reset_quiet: we/busy/req=%b want 000", {o_sr_we, o_busy, o_mem_req});
      end
    end
    start_load(24'h000A00, 16'h8030, 1'b1, 0, -1);
    t0 = t_wr;
    wait_idle(40, t0, cyc);
    vectors++;
    if (cyc !== 9 || done_cnt !== 1 || exp_sr.size() != 0 || exp_mem.size() != 0) begin
      miscompares++;
      $display("FAIL load_after_reset: cycles=%0d done=%0d sr_left=%0d mem_left=%0d want 9/1/0/0",
               cyc, done_cnt, exp_sr.size(), exp_mem.size());
    end
  endtask

  initial begin
    i_rst_n   = 1'b1;
    i_sr_addr = 16'h0;
    i_sr_data = 16'h0;
    i_sr_we   = 1'b0;
    test_reset();
    test_full_load();
    test_wrap();
    test_wait_states();
    test_error();
    test_start_clears_err();
    test_busy_writes();
    test_reset_mid_fetch();
    repeat (3) @(negedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
